mutex_merge_n: RTL and testbench

MUTEX_MERGE_N -- requirements
Module: mutex_merge_n

---
 rtl/mutex_merge_pkg.sv | 16 +
 rtl/mutex_rr_pick.sv | 34 +++
 rtl/mutex_merge_n.sv | 133 +++++++++++++
 tb/tb_mutex_merge_n.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mutex_merge_pkg.sv
// Shared types and constants for the mutex_merge_n request merger.
// Holds the FSM state type, the channel-count ceiling and the select-width helper.
package mutex_merge_pkg;

    localparam int CH_MAX = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mmState_e;

    function automatic int selWidth(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/mutex_rr_pick.sv
// Combinational grant picker: first pending channel found starting at ptr, wrapping.
// A constant ptr of zero reduces it to lowest-index-wins fixed priority.
module mutex_rr_pick
    import mutex_merge_pkg::*;
#(
    parameter int CH   = 4,
    parameter int SELW = selWidth(CH)
) (
    input  logic [CH-1:0]   pending,
    input  logic [SELW-1:0] ptr,
    output logic            valid,
    output logic [SELW-1:0] idx
);

    int cand;

    // Walk offsets from the far end so the closest candidate to ptr is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = CH - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= CH) begin
                cand = cand - CH;
            end
            if (pending[cand]) begin
                valid = 1'b1;
                idx   = SELW'(cand);
            end
        end
    end

endmodule

// File: rtl/mutex_merge_n.sv
// N-to-1 request/completion merger: one transfer downstream at a time, one pending slot per channel.
// Build option: define MUTEX_MERGE_RR_EN for round-robin grants, otherwise lowest index wins.
//
// state | meaning
// IDLE  | nothing in flight; next edge grants a pending channel if any
// BUSY  | o_sel/o_data held for the downstream until i_freeNext
module mutex_merge_n
    import mutex_merge_pkg::*;
#(
    parameter int CH = 4,
    parameter int DW = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [CH-1:0]            i_drive,
    input  logic [CH*DW-1:0]         i_data,
    output logic [CH-1:0]            o_free,
    output logic                     o_driveNext,
    output logic [DW-1:0]            o_data,
    output logic [selWidth(CH)-1:0]  o_sel,
    input  logic                     i_freeNext,
    output logic                     o_busy
);

    localparam int SELW = selWidth(CH);

    mmState_e        state;
    mmState_e        stateNext;
    logic [CH-1:0]   pending;
    logic [CH-1:0]   pendingNext;
    logic [CH-1:0]   captureMask;
    logic [CH-1:0]   freeMask;
    logic [DW-1:0]   dataReg [CH];
    logic            pickValid;
    logic [SELW-1:0] pickIdx;
    logic [SELW-1:0] rrPtr;
    logic            doGrant;
    logic            doAck;

    mutex_rr_pick #(
        .CH   (CH),
        .SELW (SELW)
    ) uPick (
        .pending (pending),
        .ptr     (rrPtr),
        .valid   (pickValid),
        .idx     (pickIdx)
    );

`ifdef MUTEX_MERGE_RR_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rrPtr <= '0;
        end else if (doGrant) begin
            rrPtr <= (pickIdx == SELW'(CH - 1)) ? '0 : pickIdx + 1'b1;
        end
    end
`else
    assign rrPtr = '0;
`endif

    // A request is only taken into an empty slot; the channel being freed this edge is still full.
    always_comb begin
        stateNext   = state;
        pendingNext = pending;
        captureMask = '0;
        freeMask    = '0;
        doGrant     = 1'b0;
        doAck       = 1'b0;

        for (int k = 0; k < CH; k++) begin
            if (i_drive[k] && !pending[k]) begin
                pendingNext[k] = 1'b1;
                captureMask[k] = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (pickValid) begin
                    stateNext = BUSY;
                    doGrant   = 1'b1;
                end
            end
            BUSY: begin
                if (i_freeNext) begin
                    stateNext          = IDLE;
                    doAck              = 1'b1;
                    pendingNext[o_sel] = 1'b0;
                    freeMask[o_sel]    = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            pending     <= '0;
            o_free      <= '0;
            o_driveNext <= 1'b0;
            o_sel       <= '0;
            o_data      <= '0;
            for (int k = 0; k < CH; k++) begin
                dataReg[k] <= '0;
            end
        end else begin
            state       <= stateNext;
            pending     <= pendingNext;
            o_free      <= freeMask;
            o_driveNext <= doGrant;
            for (int k = 0; k < CH; k++) begin
                if (captureMask[k]) begin
                    dataReg[k] <= i_data[k*DW +: DW];
                end
            end
            if (doGrant) begin
                o_sel  <= pickIdx;
                o_data <= dataReg[pickIdx];
            end
        end
    end

    assign o_busy = (state == BUSY);

    a_freeOneHot : assert property (@(posedge clk) disable iff (!rstn) $onehot0(o_free));
    a_driveInBusy : assert property (@(posedge clk) disable iff (!rstn) o_driveNext |-> o_busy);
    a_freeNotDrive : assert property (@(posedge clk) disable iff (!rstn) !(o_driveNext && (o_free != '0)));

endmodule

// File: tb/tb_mutex_merge_n.sv
// Scoreboard bench for mutex_merge_n: a rule-level model predicts grants and frees,
// a negedge monitor pops and compares whenever the DUT pulses o_driveNext or o_free.
module tb_mutex_merge_n;

    localparam int CH   = 4;
    localparam int DW   = 32;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [CH-1:0]   i_drive = '0;
    logic [CH*DW-1:0] i_data = '0;
    logic            i_freeNext = 1'b0;
    logic [CH-1:0]   o_free;
    logic            o_driveNext;
    logic [DW-1:0]   o_data;
    logic [SELW-1:0] o_sel;
    logic            o_busy;

    mutex_merge_n #(.CH(CH), .DW(DW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .o_free      (o_free),
        .o_driveNext (o_driveNext),
        .o_data      (o_data),
        .o_sel       (o_sel),
        .i_freeNext  (i_freeNext),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int cyc; int sel; logic [DW-1:0] data; } grantExp_t;
    typedef struct { int cyc; int ch; } freeExp_t;

    grantExp_t gq[$];
    freeExp_t  fq[$];

    // Reference model: one slot per channel, one transfer in flight.
    bit            mPend [CH];
    logic [DW-1:0] mData [CH];
    bit            mBusy = 1'b0;
    int            mSel = 0;
    int            mPtr = 0;
    int            mFreeNext = -1;
    bit            curBusy = 1'b0;
    bit            started = 1'b0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pickWinner();
        for (int i = 0; i < CH; i++) begin
            int k;
`ifdef MUTEX_MERGE_RR_EN
            k = (mPtr + i) % CH;
`else
            k = i;
`endif
            if (mPend[k]) return k;
        end
        return -1;
    endfunction

    task automatic step(input logic [CH-1:0] drv, input logic [CH*DW-1:0] dat,
                        input logic ack, input logic rst);
        bit accept [CH];
        int w;
        @(posedge clk);
        #2;
        i_drive    = drv;
        i_data     = dat;
        i_freeNext = ack;
        rstn       = ~rst;
        curBusy    = mBusy;
        mFreeNext  = -1;
        started    = 1'b1;
        if (rst) begin
            for (int k = 0; k < CH; k++) mPend[k] = 1'b0;
            mBusy = 1'b0;
            mPtr  = 0;
            return;
        end
        for (int k = 0; k < CH; k++) accept[k] = drv[k] && !mPend[k];
        if (!mBusy) begin
            w = pickWinner();
            if (w >= 0) begin
                gq.push_back('{cyc + 1, w, mData[w]});
                mBusy = 1'b1;
                mSel  = w;
                mPtr  = (w + 1) % CH;
            end
        end else if (ack) begin
            fq.push_back('{cyc + 1, mSel});
            mPend[mSel] = 1'b0;
            mBusy       = 1'b0;
            mFreeNext   = mSel;
        end
        for (int k = 0; k < CH; k++) begin
            if (accept[k]) begin
                mPend[k] = 1'b1;
                mData[k] = dat[k*DW +: DW];
            end
        end
    endtask

    function automatic logic [CH*DW-1:0] randData();
        logic [CH*DW-1:0] d;
        for (int k = 0; k < CH; k++) d[k*DW +: DW] = $urandom;
        return d;
    endfunction

    function automatic bit anyPend();
        for (int k = 0; k < CH; k++) if (mPend[k]) return 1'b1;
        return 1'b0;
    endfunction

    grantExp_t gExp;
    freeExp_t  fExp;

    always @(negedge clk) begin
        if (started) begin
            chk("busy", 64'(o_busy), 64'(curBusy));
            if (o_driveNext) begin
                if (gq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL grant_spurious at cycle %0d: got sel %0d want none", cyc, o_sel);
                end else begin
                    gExp = gq.pop_front();
                    chk("grant_cycle", 64'(cyc), 64'(gExp.cyc));
                    chk("grant_sel", 64'(o_sel), 64'(gExp.sel));
                    chk("grant_data", 64'(o_data), 64'(gExp.data));
                end
            end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                total++; bad++;
                $display("FAIL grant_missing at cycle %0d: got none want sel %0d", cyc, gq[0].sel);
                void'(gq.pop_front());
            end
            if (o_free != '0) begin
                if (fq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL free_spurious at cycle %0d: got %b want 0", cyc, o_free);
                end else begin
                    fExp = fq.pop_front();
                    chk("free_cycle", 64'(cyc), 64'(fExp.cyc));
                    chk("free_mask", 64'(o_free), 64'(1) << fExp.ch);
                end
            end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
                total++; bad++;
                $display("FAIL free_missing at cycle %0d: got 0 want ch %0d", cyc, fq[0].ch);
                void'(fq.pop_front());
            end
        end
    end

    task automatic checkZeroOutputs(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 64'(o_busy), 64'(0));
        chk({tag, "_sel"}, 64'(o_sel), 64'(0));
        chk({tag, "_data"}, 64'(o_data), 64'(0));
        chk({tag, "_free"}, 64'(o_free), 64'(0));
        chk({tag, "_drive"}, 64'(o_driveNext), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CH*DW-1:0] d;
        for (int k = 0; k < CH; k++) begin
            mPend[k] = 1'b0;
            mData[k] = '0;
        end
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        step('0, '0, 1'b0, 1'b0);
        checkZeroOutputs("reset");

        // Single request on channel 2, acked in the fourth cycle after the drive.
        d = '0;
        d[2*DW +: DW] = 32'hA5A5_0002;
        step(4'b0100, d, 1'b0, 1'b0);
        repeat (3) step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        repeat (2) step('0, '0, 1'b0, 1'b0);

        // Simultaneous burst with immediate downstream acks, twice.
        for (int r = 0; r < 2; r++) begin
            step(4'b1111, randData(), 1'b0, 1'b0);
            for (int i = 0; i < 10; i++) step('0, '0, mBusy, 1'b0);
        end

        // Duplicate drive on channel 1 with a changed payload.
        step(4'b0010, randData(), 1'b0, 1'b0);
        step(4'b0010, randData(), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0010, randData(), (i == 3), 1'b0);
        repeat (2) step('0, '0, 1'b0, 1'b0);

        // Channel 0 re-drives on each of its frees while channel 3 waits.
        step(4'b1001, randData(), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            step((i < 10 && mFreeNext == 0) ? 4'b0001 : 4'b0000, randData(), mBusy, 1'b0);

        // Reset while busy, then a fresh request.
        step(4'b0100, randData(), 1'b0, 1'b0);
        repeat (2) step('0, '0, 1'b0, 1'b0);
        step(4'b1111, randData(), 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b0);
        checkZeroOutputs("midreset");
        step(4'b1000, randData(), 1'b0, 1'b0);
        repeat (3) step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4 == 0) ? CH'($urandom) : '0, randData(),
                 mBusy && ($urandom % 2 == 0), ($urandom % 400 == 0));
        end

        for (int i = 0; i < 100; i++) begin
            if (!mBusy && !anyPend() && gq.size() == 0 && fq.size() == 0) break;
            step('0, '0, mBusy, 1'b0);
        end
        repeat (2) step('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("drain_grants", 64'(gq.size()), 64'(0));
        chk("drain_frees", 64'(fq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
